hazard_ctrl_unit: RTL and testbench

//  Front-end pipeline controller: sequences PC, IF/ID and ID/EX registers.

---
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the fetch/decode stages and the front-end hazard controller.
// Optional counters appear only when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
  logic [31:0] if_id_inst;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_rt;
  logic        branch_taken;
  logic        imem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        imem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  modport master (
    output if_id_inst, id_ex_mem_read, id_ex_rt, branch_taken, imem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, imem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , input stall_count, flush_count
`endif
  );

  modport slave (
    input  if_id_inst, id_ex_mem_read, id_ex_rt, branch_taken, imem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, imem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , output stall_count, flush_count
`endif
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Front-end pipeline controller: load-use stalls, branch flushes and imem wait handling.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush cycle counters).
module hazard_ctrl_unit #(
  parameter int LOAD_USE_STALL = 1,
  parameter int IMEM_TIMEOUT   = 255
) (
  input logic          clock,
  input logic          reset_n,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_LDSTALL, S_IWAIT} state_t;

  localparam logic [1:0] STALL_INIT  = 2'(LOAD_USE_STALL - 1);
  localparam logic [7:0] TIMEOUT_CNT = 8'(IMEM_TIMEOUT);

  state_t     r_state;
  logic [1:0] r_stall_cnt;
  logic [7:0] r_wait_cnt;
  logic       r_timeout;

  logic [5:0] w_opcode;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_uses_rt;
  logic       w_hazard;
  logic       w_pc_write;
  logic       w_if_id_write;
  logic       w_flush;
  logic       w_bubble;
  logic       w_unused_inst;

  assign w_opcode      = bus.if_id_inst[31:26];
  assign w_rs          = bus.if_id_inst[25:21];
  assign w_rt          = bus.if_id_inst[20:16];
  assign w_unused_inst = ^bus.if_id_inst[15:0];

  // R-type, beq, bne and sw read rt as a source; other formats write it.
  assign w_uses_rt = (w_opcode == 6'h00) || (w_opcode == 6'h04) ||
                     (w_opcode == 6'h05) || (w_opcode == 6'h2B);
  assign w_hazard  = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
                     ((bus.id_ex_rt == w_rs) || (w_uses_rt && (bus.id_ex_rt == w_rt)));

  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_flush       = 1'b0;
    w_bubble      = 1'b0;
    if (!reset_n) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_flush       = 1'b1;
      w_bubble      = 1'b1;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_hazard) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_bubble      = 1'b1;
          end else if (bus.branch_taken) begin
            w_flush = 1'b1;
          end else if (!bus.imem_ready) begin
            w_pc_write = 1'b0;
            w_flush    = 1'b1;
          end
        end
        S_LDSTALL: begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_bubble      = 1'b1;
        end
        S_IWAIT: begin
          if (!bus.imem_ready) begin
            w_pc_write = 1'b0;
            w_flush    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_write     = w_pc_write;
  assign bus.if_id_write  = w_if_id_write;
  assign bus.if_id_flush  = w_flush;
  assign bus.id_ex_bubble = w_bubble;
  assign bus.imem_timeout = r_timeout;

  // State advances on the falling edge, in step with the pipeline registers.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RUN;
      r_stall_cnt <= 2'd0;
      r_wait_cnt  <= 8'd0;
      r_timeout   <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (w_hazard) begin
            if (LOAD_USE_STALL > 1) begin
              r_stall_cnt <= STALL_INIT;
              r_state     <= S_LDSTALL;
            end
          end else if (!bus.branch_taken && !bus.imem_ready) begin
            r_wait_cnt <= 8'd1;
            r_state    <= S_IWAIT;
          end
        end
        S_LDSTALL: begin
          r_stall_cnt <= r_stall_cnt - 2'd1;
          if (r_stall_cnt == 2'd1) r_state <= S_RUN;
        end
        S_IWAIT: begin
          if (!bus.imem_ready) begin
            if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == TIMEOUT_CNT) r_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= 8'd0;
            r_state    <= S_RUN;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (!w_pc_write && (r_stall_count != 16'hFFFF)) r_stall_count <= r_stall_count + 16'd1;
      if (w_flush && (r_flush_count != 16'hFFFF)) r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign bus.stall_count = r_stall_count;
  assign bus.flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed scoreboard bench for hazard_ctrl_unit (LOAD_USE_STALL=2, IMEM_TIMEOUT=3).
module tb_hazard_ctrl_unit;
  logic clock;
  logic reset_n;

  hazard_ctrl_if bus ();

  hazard_ctrl_unit #(.LOAD_USE_STALL(2), .IMEM_TIMEOUT(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct packed {
    logic pcw;
    logic ifw;
    logic fl;
    logic bb;
    logic to;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] ADD_355 = {6'h00, 5'd5, 5'd2, 5'd3, 5'd0, 6'h20}; // add $3,$5,$2
  localparam logic [31:0] ADD_R0  = {6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h20}; // add $3,$0,$2
  localparam logic [31:0] SW_RT5  = {6'h2B, 5'd4, 5'd5, 16'h0000};          // sw $5,0($4)
  localparam logic [31:0] ADDI_RT5 = {6'h08, 5'd4, 5'd5, 16'h0001};         // addi $5,$4,1

  task automatic cmp1(input string tag, input string fld, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, exp);
    end
  endtask

  task automatic check();
    exp_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    cmp1(t, "pc_write",     bus.pc_write,     e.pcw);
    cmp1(t, "if_id_write",  bus.if_id_write,  e.ifw);
    cmp1(t, "if_id_flush",  bus.if_id_flush,  e.fl);
    cmp1(t, "id_ex_bubble", bus.id_ex_bubble, e.bb);
    cmp1(t, "imem_timeout", bus.imem_timeout, e.to);
  endtask

  task automatic drive(input logic [31:0] inst, input logic mr, input logic [4:0] rt,
                       input logic br, input logic rdy);
    bus.if_id_inst     = inst;
    bus.id_ex_mem_read = mr;
    bus.id_ex_rt       = rt;
    bus.branch_taken   = br;
    bus.imem_ready     = rdy;
  endtask

  task automatic expect_now(input string tag, input exp_t e);
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // One pipeline cycle: drive after the falling edge, sample at the rising edge.
  task automatic step(input string tag, input logic [31:0] inst, input logic mr,
                      input logic [4:0] rt, input logic br, input logic rdy, input exp_t e);
    @(negedge clock);
    #1;
    drive(inst, mr, rt, br, rdy);
    expect_now(tag, e);
    @(posedge clock);
    check();
  endtask

  localparam exp_t E_RUN    = '{pcw:1'b1, ifw:1'b1, fl:1'b0, bb:1'b0, to:1'b0};
  localparam exp_t E_STALL  = '{pcw:1'b0, ifw:1'b0, fl:1'b0, bb:1'b1, to:1'b0};
  localparam exp_t E_BRANCH = '{pcw:1'b1, ifw:1'b1, fl:1'b1, bb:1'b0, to:1'b0};
  localparam exp_t E_WAIT   = '{pcw:1'b0, ifw:1'b1, fl:1'b1, bb:1'b0, to:1'b0};
  localparam exp_t E_RESET  = '{pcw:1'b0, ifw:1'b0, fl:1'b1, bb:1'b1, to:1'b0};
  localparam exp_t E_RUN_TO = '{pcw:1'b1, ifw:1'b1, fl:1'b0, bb:1'b0, to:1'b1};

  initial begin
    reset_n = 1'b0;
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    expect_now("reset", E_RESET);
    check();
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) step("run_idle", NOP, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN);

    step("lw_use_c1", ADD_355, 1'b1, 5'd5, 1'b0, 1'b1, E_STALL);
    step("lw_use_c2", ADD_355, 1'b1, 5'd5, 1'b0, 1'b1, E_STALL);
    step("lw_use_c3", ADD_355, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN);

    step("load_r0", ADD_R0, 1'b1, 5'd0, 1'b0, 1'b1, E_RUN);

    step("sw_rt_c1", SW_RT5, 1'b1, 5'd5, 1'b0, 1'b1, E_STALL);
    step("sw_rt_c2", SW_RT5, 1'b1, 5'd5, 1'b0, 1'b1, E_STALL);
    step("sw_rt_c3", SW_RT5, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN);

    step("addi_rt", ADDI_RT5, 1'b1, 5'd5, 1'b0, 1'b1, E_RUN);

    step("branch_nordy", NOP, 1'b0, 5'd0, 1'b1, 1'b0, E_BRANCH);
    // A hazard right after proves the branch left the controller in RUN.
    step("post_br_hz1", ADD_355, 1'b1, 5'd5, 1'b0, 1'b1, E_STALL);
    step("post_br_hz2", ADD_355, 1'b1, 5'd5, 1'b0, 1'b1, E_STALL);
    step("post_br_run", NOP, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN);

    step("hz_over_br", ADD_355, 1'b1, 5'd5, 1'b1, 1'b0, E_STALL);
    step("ldstall_ign", ADD_355, 1'b1, 5'd5, 1'b1, 1'b0, E_STALL);
    step("hz_over_br_end", NOP, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN);

    for (int i = 0; i < 4; i++) step("iwait", NOP, 1'b0, 5'd0, 1'b0, 1'b0, E_WAIT);
    step("iwait_exit", NOP, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN_TO);
    step("timeout_sticky", NOP, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN_TO);

    step("pre_rst_stall", ADD_355, 1'b1, 5'd5, 1'b0, 1'b1, '{pcw:1'b0, ifw:1'b0, fl:1'b0, bb:1'b1, to:1'b1});
    @(negedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    expect_now("async_reset", E_RESET);
    check();
    @(posedge clock);
    #1;
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b1);
    reset_n = 1'b1;
    // A wait-state response (not a stall) shows the stall count was discarded.
    step("post_rst_wait", NOP, 1'b0, 5'd0, 1'b0, 1'b0, E_WAIT);
    step("post_rst_run", NOP, 1'b0, 5'd0, 1'b0, 1'b1, E_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
